router_input_channel: RTL and testbench

Receive-side stage of a router port. It takes flits from the upstream link and buffers them in two polarity-selected virtual-channel FIFOs. It computes the XY route for the head flit of the VC being drained, then presents request, route and data to the switch / router_output_channel side, popping a flit only on grant. It is the producer that feeds router_output_channel's data_in.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_vc_fifo.sv | 62 ++++++
 rtl/router_input_channel.sv | 96 +++++++++
 tb/tb_router_input_channel.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared flit layout and one-hot output direction constants
//   FLIT_W                 : flit width in bits
//   DEST_X_HI/LO, DEST_Y_*  : destination coordinate fields inside a flit
//   DIR_N/S/E/W/LOCAL      : one-hot output port codes, [4]=N [3]=S [2]=E [1]=W [0]=LOCAL
package router_pkg;

    localparam int FLIT_W    = 64;
    localparam int DEST_X_HI = 55;
    localparam int DEST_X_LO = 52;
    localparam int DEST_Y_HI = 51;
    localparam int DEST_Y_LO = 48;

    localparam logic [4:0] DIR_N     = 5'b10000;
    localparam logic [4:0] DIR_S     = 5'b01000;
    localparam logic [4:0] DIR_E     = 5'b00100;
    localparam logic [4:0] DIR_W     = 5'b00010;
    localparam logic [4:0] DIR_LOCAL = 5'b00001;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/router_vc_fifo.sv
// rtl/router_vc_fifo.sv - synchronous flit FIFO backing one virtual channel
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   push, data_in  : store data_in at the edge (ignored when full)
//   pop            : advance the head pointer at the edge (ignored when empty)
//   full, empty    : occupancy flags from the registered count
//   head           : flit at the read pointer; undefined while empty
module router_vc_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  flit_t data_in,
    output logic  full,
    output logic  empty,
    output flit_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    flit_t            mem [DEPTH];

    logic do_push;
    logic do_pop;

    // Guarding here keeps count inside 0..DEPTH regardless of the caller.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/router_input_channel.sv
// rtl/router_input_channel.sv - router receive port: two polarity-selected VC FIFOs plus XY routing
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   polarity            : 1 -> write VC0 / drain VC1, 0 -> write VC1 / drain VC0
//   send_in, data_in    : upstream flit offer
//   ready_out           : write VC not full
//   req, route, data_out: head of drain VC, its one-hot XY output port, its payload
//   grant               : switch takes data_out this cycle
//   drop_err            : sticky, a flit was offered while ready_out was low
module router_input_channel
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MY_X  = 0,
    parameter int MY_Y  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              send_in,
    input  logic [FLIT_W-1:0] data_in,
    output logic              ready_out,
    output logic              req,
    output logic [4:0]        route,
    output logic [FLIT_W-1:0] data_out,
    input  logic              grant,
    output logic              drop_err
);

    localparam logic [3:0] MY_X4 = 4'(MY_X);
    localparam logic [3:0] MY_Y4 = 4'(MY_Y);

    logic  push0, push1, pop0, pop1;
    logic  full0, full1, empty0, empty1;
    flit_t head0, head1;
    flit_t head;
    logic  accept;
    logic  [3:0] dest_x, dest_y;

    // Opposite phases for write and drain, so one VC is never pushed and popped together.
    assign ready_out = polarity ? !full0 : !full1;
    assign accept    = send_in && ready_out;
    assign push0     = accept && polarity;
    assign push1     = accept && !polarity;

    assign req      = polarity ? !empty1 : !empty0;
    assign head     = polarity ? head1 : head0;
    assign data_out = req ? head : '0;
    assign pop0     = req && grant && !polarity;
    assign pop1     = req && grant && polarity;

    router_vc_fifo #(.DEPTH(DEPTH)) u_vc0 (
        .clk     (clk),
        .reset   (reset),
        .push    (push0),
        .pop     (pop0),
        .data_in (data_in),
        .full    (full0),
        .empty   (empty0),
        .head    (head0)
    );

    router_vc_fifo #(.DEPTH(DEPTH)) u_vc1 (
        .clk     (clk),
        .reset   (reset),
        .push    (push1),
        .pop     (pop1),
        .data_in (data_in),
        .full    (full1),
        .empty   (empty1),
        .head    (head1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_err <= 1'b0;
        end else if (send_in && !ready_out) begin
            drop_err <= 1'b1;
        end
    end

    assign dest_x = head[DEST_X_HI:DEST_X_LO];
    assign dest_y = head[DEST_Y_HI:DEST_Y_LO];

    // Dimension-order routing: resolve X fully before Y.
    always_comb begin
        route = '0;
        if (req) begin
            if (dest_x > MY_X4)      route = DIR_E;
            else if (dest_x < MY_X4) route = DIR_W;
            else if (dest_y > MY_Y4) route = DIR_N;
            else if (dest_y < MY_Y4) route = DIR_S;
            else                     route = DIR_LOCAL;
        end
    end

endmodule

// File: tb/tb_router_input_channel.sv
// tb/tb_router_input_channel.sv - bench for router_input_channel with a queue-based reference model
module tb_router_input_channel;

    localparam int DEPTH = 4;
    localparam int MYX   = 1;
    localparam int MYY   = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        polarity = 1'b1;
    logic        send_in = 1'b0;
    logic [63:0] data_in = '0;
    logic        ready_out;
    logic        req;
    logic [4:0]  route;
    logic [63:0] data_out;
    logic        grant = 1'b0;
    logic        drop_err;

    int tests = 0;
    int fails = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        m_drop = 1'b0;

    always #5 clk = ~clk;

    router_input_channel #(.DEPTH(DEPTH), .MY_X(MYX), .MY_Y(MYY)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .send_in   (send_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .req       (req),
        .route     (route),
        .data_out  (data_out),
        .grant     (grant),
        .drop_err  (drop_err)
    );

    function automatic logic [63:0] mk(input int dx, input int dy);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[55:52] = 4'(dx);
        f[51:48] = 4'(dy);
        return f;
    endfunction

    function automatic logic [4:0] exp_route(input logic [63:0] f);
        int dx, dy;
        dx = int'(f[55:52]);
        dy = int'(f[51:48]);
        if (dx > MYX) return 5'b00100;
        if (dx < MYX) return 5'b00010;
        if (dy > MYY) return 5'b10000;
        if (dy < MYY) return 5'b01000;
        return 5'b00001;
    endfunction

    task automatic cycle(input logic pol, input logic snd, input logic [63:0] d,
                         input logic gnt, input logic rst, input logic chk);
        logic        e_ready, e_req;
        logic [63:0] e_data;
        logic [4:0]  e_route;
        int          wsize, dsize;
        polarity = pol; send_in = snd; data_in = d; grant = gnt; reset = rst;
        #2;
        wsize   = pol ? q0.size() : q1.size();
        dsize   = pol ? q1.size() : q0.size();
        e_ready = (wsize < DEPTH);
        e_req   = (dsize > 0);
        e_data  = e_req ? (pol ? q1[0] : q0[0]) : 64'b0;
        e_route = e_req ? exp_route(e_data) : 5'b0;
        if (chk) begin
            tests++;
            assert (ready_out === e_ready) else begin
                fails++; $error("FAIL ready_out got %b exp %b t=%0t", ready_out, e_ready, $time);
            end
            tests++;
            assert (req === e_req) else begin
                fails++; $error("FAIL req got %b exp %b t=%0t", req, e_req, $time);
            end
            tests++;
            assert (route === e_route) else begin
                fails++; $error("FAIL route got %b exp %b t=%0t", route, e_route, $time);
            end
            tests++;
            assert (data_out === e_data) else begin
                fails++; $error("FAIL data_out got %h exp %h t=%0t", data_out, e_data, $time);
            end
            tests++;
            assert (drop_err === m_drop) else begin
                fails++; $error("FAIL drop_err got %b exp %b t=%0t", drop_err, m_drop, $time);
            end
        end
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); m_drop = 1'b0;
        end else begin
            if (snd) begin
                if (!e_ready)  m_drop = 1'b1;
                else if (pol)  q0.push_back(d);
                else           q1.push_back(d);
            end
            if (e_req && gnt) begin
                if (pol) void'(q1.pop_front());
                else     void'(q0.pop_front());
            end
        end
        #1;
    endtask

    initial begin
        #1;
        // Reset with a flit offered: nothing may be stored.
        cycle(1'b1, 1'b1, mk(3, 0), 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

        // East route: write at pol=1, drain at pol=0, grant clears it.
        cycle(1'b1, 1'b1, mk(3, 0), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Fill VC0 with N/S/W/LOCAL heads, then overflow it.
        cycle(1'b1, 1'b1, mk(1, 2), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, mk(1, 0), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, mk(0, 1), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, mk(1, 1), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, mk(5, 5), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        end

        // VC1 order and pointer wrap with interleaved grants.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, mk(i % 3, (i + 1) % 3), 1'b0, 1'b0, 1'b1);
            cycle(1'b1, 1'b0, 64'h0, 1'(i % 2), 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        end

        // Both VCs partly full, VC0 full, reset while a flit is offered.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, mk(2, 2), 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b1, mk(0, 0), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, mk(0, 0), 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic, with stretches of static polarity.
        begin
            logic pol;
            pol = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ((i / 40) % 3 != 2) pol = ~pol;
                cycle(pol, 1'($urandom_range(0, 1)),
                      mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15))),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
